// File: rtl/decod_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : decod_rr_arbiter_4
// Brief    : Four-way round-robin arbiter with hold-time preemption and a
//            one-hot grant bus decoded from the registered owner index.
// Revision : 1.0 - initial release
// ============================================================================
module decod_rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);
    localparam int                 c_HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_MAX_HOLD = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]          r_state;
    logic [1:0]          r_ptr;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [1:0]          r_gnt_id;
    logic                r_gnt_valid;
    logic [3:0]          r_gnt;

    logic [0:0]          w_state_nxt;
    logic [1:0]          w_ptr_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [1:0]          w_id_nxt;
    logic                w_valid_nxt;
    logic [3:0]          w_gnt_nxt;

    logic [1:0]          w_search_ptr;
    logic                w_found;
    logic [1:0]          w_win_id;
    logic [3:0]          w_owner_oh;
    logic                w_others;
    logic                w_release;

    // State register: all outputs come straight from flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= 2'd3;
            r_hold_cnt  <= '0;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt_id    <= w_id_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

    // On release the pointer becomes the old owner, so the search starts just
    // past it and the preempted owner is naturally considered last.
    assign w_search_ptr = (r_state == c_ST_GRANT) ? r_gnt_id : r_ptr;

    // Descending scan: the last hit, i.e. the nearest to the pointer, wins
    always_comb begin
        w_found  = 1'b0;
        w_win_id = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (req[w_search_ptr + 2'(i)]) begin
                w_found  = 1'b1;
                w_win_id = w_search_ptr + 2'(i);
            end
        end
    end

    assign w_owner_oh = 4'b0001 << r_gnt_id;
    assign w_others   = |(req & ~w_owner_oh);
    assign w_release  = !req[r_gnt_id] || !enable ||
                        ((r_hold_cnt == c_MAX_HOLD) && w_others);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_id_nxt    = r_gnt_id;
        w_valid_nxt = r_gnt_valid;
        case (r_state)
            c_ST_IDLE: begin
                if (enable && w_found) begin
                    w_state_nxt = c_ST_GRANT;
                    w_id_nxt    = w_win_id;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = c_HOLD_ONE;
                end
            end
            c_ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = r_gnt_id;
                    if (enable && w_found) begin
                        w_id_nxt    = w_win_id;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = c_HOLD_ONE;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_id_nxt    = 2'd0;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold_cnt != c_MAX_HOLD) begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_id_nxt    = 2'd0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Output decode feeding the grant register
    always_comb begin
        w_gnt_nxt = w_valid_nxt ? (4'b0001 << w_id_nxt) : 4'b0000;
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_decod_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_decod_rr_arbiter_4
// Brief    : Directed scenarios plus randomized traffic checked each cycle
//            against a behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decod_rr_arbiter_4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: owner index (-1 = none), last owner, hold length
    int m_owner = -1;
    int m_ptr   = 3;
    int m_hold  = 0;

    decod_rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int search(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic en, input logic [3:0] r);
        logic [3:0] others;
        if (!rn) begin
            m_owner = -1; m_ptr = 3; m_hold = 0;
        end else if (m_owner < 0) begin
            if (en && r != 4'b0000) begin
                m_owner = search(m_ptr, r);
                m_hold  = 1;
            end
        end else begin
            others = r & ~(4'b0001 << m_owner);
            if (!r[m_owner] || !en || (m_hold == MAX_HOLD && others != 4'b0000)) begin
                m_ptr   = m_owner;
                m_owner = en ? search(m_ptr, r) : -1;
                m_hold  = (m_owner >= 0) ? 1 : 0;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check("gnt", {28'd0, gnt}, {28'd0, exp_gnt});
        check("gnt_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
        if (m_owner >= 0) check("gnt_id", {30'd0, gnt_id}, m_owner);
    endtask

    // Apply inputs, take one rising edge, then compare just after it
    task automatic step(input logic rn, input logic en, input logic [3:0] r);
        rst_n  = rn;
        enable = en;
        req    = r;
        @(posedge clk);
        model_edge(rn, en, r);
        #1;
        compare_model();
    endtask

    initial begin
        logic [3:0] r;
        logic       en;
        logic       rn;

        // Reset with everything requesting
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b1, 4'b1111);
        check("rst_gnt", {28'd0, gnt}, 32'h0);
        check("rst_id", {30'd0, gnt_id}, 32'h0);
        check("rst_valid", {31'd0, gnt_valid}, 32'h0);

        // Rotation with constant full request
        step(1'b1, 1'b1, 4'b1111);
        check("first_gnt", {28'd0, gnt}, 32'h1);
        for (int c = 0; c < 4 * MAX_HOLD; c++) begin
            step(1'b1, 1'b1, 4'b1111);
            check("rotation", {28'd0, gnt}, 32'h1 << (((c + 1) / MAX_HOLD) % 4));
        end

        // Single requester, then release to idle
        step(1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b0001);
        check("single_gnt", {28'd0, gnt}, 32'h1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 4'b0001);
        check("single_held", {28'd0, gnt}, 32'h1);
        step(1'b1, 1'b1, 4'b0000);
        check("single_drop", {28'd0, gnt}, 32'h0);

        // Owner drops while another waits: immediate handoff
        step(1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b0010);
        step(1'b1, 1'b1, 4'b0110);
        check("handoff_owner", {28'd0, gnt}, 32'h2);
        step(1'b1, 1'b1, 4'b0100);
        check("handoff_gnt", {28'd0, gnt}, 32'h4);
        check("handoff_valid", {31'd0, gnt_valid}, 32'h1);

        // Sole owner is never preempted; a new requester preempts at saturation
        step(1'b0, 1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b1, 4'b1000);
            check("sole_owner", {28'd0, gnt}, 32'h8);
        end
        step(1'b1, 1'b1, 4'b1001);
        check("sole_preempt", {28'd0, gnt}, 32'h1);

        // Enable drop overrides requests; resume continues past old owner
        step(1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b0100);
        check("en_owner", {28'd0, gnt}, 32'h4);
        step(1'b1, 1'b0, 4'b1111);
        check("en_drop", {28'd0, gnt}, 32'h0);
        step(1'b1, 1'b1, 4'b1111);
        check("en_resume", {28'd0, gnt}, 32'h8);
        check("en_resume_id", {30'd0, gnt_id}, 32'h3);

        // Randomized traffic; the owner usually keeps requesting so holds grow
        for (int c = 0; c < 600; c++) begin
            r  = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            en = ($urandom_range(0, 15) != 0);
            rn = ($urandom_range(0, 63) != 0);
            step(rn, en, r);
            check("onehot", {31'd0, $countones(gnt) <= 1}, 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
